// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants for the 16-bit register file
package reg_file_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  // Register 0 is hard-wired: reads 0, never busy, ignores writes and reserves.
  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/reg_file_word.sv
// rtl/reg_file_word.sv - one storage word with load enable and pending (busy) bit
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset; clears word and busy
//   load     - write enable for this word; also clears busy
//   set_busy - reserve request; sets busy and wins over the clear from load
//   d        - write data
//   q        - stored word
//   busy     - pending flag
module reg_file_word
  import reg_file_pkg::*;
#(
  parameter int DATA_W = reg_file_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              set_busy,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              busy
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      busy <= 1'b0;
    end else begin
      if (load) begin
        q <= d;
      end
      // A reserve landing in the same cycle as the write leaves the word pending.
      if (set_busy) begin
        busy <= 1'b1;
      end else if (load) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_file_16b.sv
// rtl/reg_file_16b.sv - 32 x 16-bit register file, two combinational read ports, busy scoreboard
//
// Ports:
//   clk              - clock, rising edge
//   rst              - synchronous active-high reset; also forces all read outputs to 0
//   we, waddr, wdata - write request (write to register 0 is dropped)
//   rsv, rsv_addr    - reserve request, marks the target register pending
//   raddr_a/raddr_b  - read addresses
//   rdata_a/rdata_b  - read data, with write-through bypass of a same-cycle write
//   busy_a/busy_b    - pending flag of the addressed register, cleared by a same-cycle write
module reg_file_16b
  import reg_file_pkg::*;
#(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              busy_a,
  output logic              busy_b
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0]   words [NUM_REGS];
  logic [NUM_REGS-1:0] busy_bits;

  // One-hot decoders; address 0 has no output so register 0 never loads or reserves.
  logic [NUM_REGS-1:1] we_dec;
  logic [NUM_REGS-1:1] rsv_dec;

  always_comb begin
    we_dec  = '0;
    rsv_dec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      we_dec[i]  = we  && (waddr    == ADDR_W'(i));
      rsv_dec[i] = rsv && (rsv_addr == ADDR_W'(i));
    end
  end

  assign words[0]     = '0;
  assign busy_bits[0] = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_word
    reg_file_word #(
      .DATA_W (DATA_W)
    ) u_word (
      .clk      (clk),
      .rst      (rst),
      .load     (we_dec[i]),
      .set_busy (rsv_dec[i]),
      .d        (wdata),
      .q        (words[i]),
      .busy     (busy_bits[i])
    );
  end

  logic hit_a;
  logic hit_b;

  // Bypass matches the register the write will actually update, so r0 is excluded.
  always_comb begin
    hit_a = we && (waddr != ZERO_ADDR) && (waddr == raddr_a);
    hit_b = we && (waddr != ZERO_ADDR) && (waddr == raddr_b);
  end

  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    busy_a  = 1'b0;
    busy_b  = 1'b0;
    if (!rst) begin
      rdata_a = hit_a ? wdata : words[raddr_a];
      rdata_b = hit_b ? wdata : words[raddr_b];
      busy_a  = busy_bits[raddr_a] && !hit_a;
      busy_b  = busy_bits[raddr_b] && !hit_b;
    end
  end

endmodule

// File: tb/tb_reg_file_16b.sv
// tb/tb_reg_file_16b.sv - scoreboard bench for reg_file_16b
module tb_reg_file_16b;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [15:0] wdata;
  logic        rsv;
  logic [4:0]  rsv_addr;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic [15:0] rdata_a;
  logic [15:0] rdata_b;
  logic        busy_a;
  logic        busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_file_16b #(.DATA_W(16), .ADDR_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .rsv      (rsv),
    .rsv_addr (rsv_addr),
    .raddr_a  (raddr_a),
    .raddr_b  (raddr_b),
    .rdata_a  (rdata_a),
    .rdata_b  (rdata_b),
    .busy_a   (busy_a),
    .busy_b   (busy_b)
  );

  // expected = {rdata_a, rdata_b, busy_a, busy_b}
  typedef struct {
    logic        r;
    logic        w;
    logic [4:0]  wa;
    logic [15:0] wd;
    logic        rv;
    logic [4:0]  rva;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [33:0] exp;
  } step_t;

  typedef struct {
    int          id;
    logic [33:0] exp;
  } sb_t;

  sb_t sb[$];

  task automatic drive(input step_t s);
    rst      = s.r;
    we       = s.w;
    waddr    = s.wa;
    wdata    = s.wd;
    rsv      = s.rv;
    rsv_addr = s.rva;
    raddr_a  = s.a;
    raddr_b  = s.b;
  endtask

  task automatic test_reset();
    sb_t   e;
    step_t s;
    s = '{1'b1, 1'b1, 5'd4, 16'h1111, 1'b1, 5'd4, 5'd4, 5'd4, 34'h0};
    drive(s);
    sb.push_back('{0, 34'h0});
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if ({rdata_a, rdata_b, busy_a, busy_b} !== e.exp) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", {rdata_a, rdata_b, busy_a, busy_b}, e.exp);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      s = '{1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 5'(i), 5'(31 - i), 34'h0};
      drive(s);
      sb.push_back('{i, 34'h0});
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({rdata_a, rdata_b, busy_a, busy_b} !== e.exp) begin
        n_fail++;
        $display("FAIL reset_read addr %0d: got %h expected %h", e.id, {rdata_a, rdata_b, busy_a, busy_b}, e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bypass();
    sb_t   e;
    step_t st [2];
    st[0] = '{1'b0, 1'b1, 5'd7, 16'hBEEF, 1'b0, 5'd0, 5'd7, 5'd8, {16'hBEEF, 16'h0000, 1'b0, 1'b0}};
    st[1] = '{1'b0, 1'b0, 5'd7, 16'h0000, 1'b0, 5'd0, 5'd7, 5'd7, {16'hBEEF, 16'hBEEF, 1'b0, 1'b0}};
    foreach (st[k]) begin
      drive(st[k]);
      sb.push_back('{k, st[k].exp});
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({rdata_a, rdata_b, busy_a, busy_b} !== e.exp) begin
        n_fail++;
        $display("FAIL bypass step %0d: got %h expected %h", e.id, {rdata_a, rdata_b, busy_a, busy_b}, e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_reg();
    sb_t   e;
    step_t st [3];
    st[0] = '{1'b0, 1'b1, 5'd0, 16'h1234, 1'b1, 5'd0, 5'd0, 5'd0, 34'h0};
    st[1] = '{1'b0, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 5'd0, 5'd0, 34'h0};
    st[2] = '{1'b0, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 5'd0, 5'd7, {16'h0000, 16'hBEEF, 1'b0, 1'b0}};
    foreach (st[k]) begin
      drive(st[k]);
      sb.push_back('{k, st[k].exp});
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({rdata_a, rdata_b, busy_a, busy_b} !== e.exp) begin
        n_fail++;
        $display("FAIL zero_reg step %0d: got %h expected %h", e.id, {rdata_a, rdata_b, busy_a, busy_b}, e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reserve();
    sb_t   e;
    step_t st [4];
    st[0] = '{1'b0, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd3, 5'd3, 5'd3, 34'h0};
    st[1] = '{1'b0, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 5'd3, 5'd4, {16'h0000, 16'h0000, 1'b1, 1'b0}};
    st[2] = '{1'b0, 1'b1, 5'd3, 16'h00AA, 1'b0, 5'd0, 5'd3, 5'd3, {16'h00AA, 16'h00AA, 1'b0, 1'b0}};
    st[3] = '{1'b0, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 5'd3, 5'd3, {16'h00AA, 16'h00AA, 1'b0, 1'b0}};
    foreach (st[k]) begin
      drive(st[k]);
      sb.push_back('{k, st[k].exp});
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({rdata_a, rdata_b, busy_a, busy_b} !== e.exp) begin
        n_fail++;
        $display("FAIL reserve step %0d: got %h expected %h", e.id, {rdata_a, rdata_b, busy_a, busy_b}, e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rsv_and_write();
    sb_t   e;
    step_t st [2];
    st[0] = '{1'b0, 1'b1, 5'd5, 16'h5555, 1'b1, 5'd5, 5'd5, 5'd5, {16'h5555, 16'h5555, 1'b0, 1'b0}};
    st[1] = '{1'b0, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 5'd5, 5'd5, {16'h5555, 16'h5555, 1'b1, 1'b1}};
    foreach (st[k]) begin
      drive(st[k]);
      sb.push_back('{k, st[k].exp});
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({rdata_a, rdata_b, busy_a, busy_b} !== e.exp) begin
        n_fail++;
        $display("FAIL rsv_write step %0d: got %h expected %h", e.id, {rdata_a, rdata_b, busy_a, busy_b}, e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_dominates();
    sb_t   e;
    step_t st [3];
    st[0] = '{1'b1, 1'b1, 5'd9, 16'hFFFF, 1'b1, 5'd9, 5'd9, 5'd5, 34'h0};
    st[1] = '{1'b0, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 5'd9, 5'd5, 34'h0};
    st[2] = '{1'b0, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 5'd7, 5'd3, 34'h0};
    foreach (st[k]) begin
      drive(st[k]);
      sb.push_back('{k, st[k].exp});
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({rdata_a, rdata_b, busy_a, busy_b} !== e.exp) begin
        n_fail++;
        $display("FAIL reset_dominates step %0d: got %h expected %h", e.id, {rdata_a, rdata_b, busy_a, busy_b}, e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  // Random traffic against a behavioural model, starting from a reset.
  task automatic test_back_to_back();
    sb_t         e;
    step_t       s;
    logic [15:0] mem [32];
    logic        bsy [32];
    logic [15:0] ea;
    logic [15:0] eb;
    logic        ba;
    logic        bb;
    s = '{1'b1, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 5'd0, 5'd0, 34'h0};
    drive(s);
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      mem[i] = 16'h0;
      bsy[i] = 1'b0;
    end
    for (int n = 0; n < 300; n++) begin
      s.r   = 1'b0;
      s.w   = ($urandom_range(0, 2) != 0);
      s.wa  = 5'($urandom_range(0, 31));
      s.wd  = 16'($urandom);
      s.rv  = ($urandom_range(0, 3) == 0);
      s.rva = ($urandom_range(0, 3) == 0) ? s.wa : 5'($urandom_range(0, 31));
      s.a   = ($urandom_range(0, 2) == 0) ? s.wa : 5'($urandom_range(0, 31));
      s.b   = ($urandom_range(0, 3) == 0) ? s.a : 5'($urandom_range(0, 31));
      ea = (s.w && s.wa != 5'd0 && s.wa == s.a) ? s.wd : mem[s.a];
      eb = (s.w && s.wa != 5'd0 && s.wa == s.b) ? s.wd : mem[s.b];
      ba = bsy[s.a] && !(s.w && s.wa == s.a);
      bb = bsy[s.b] && !(s.w && s.wa == s.b);
      drive(s);
      sb.push_back('{n, {ea, eb, ba, bb}});
      if (s.w && s.wa != 5'd0) begin
        mem[s.wa] = s.wd;
        bsy[s.wa] = 1'b0;
      end
      if (s.rv && s.rva != 5'd0) begin
        bsy[s.rva] = 1'b1;
      end
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({rdata_a, rdata_b, busy_a, busy_b} !== e.exp) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got %h expected %h", e.id, {rdata_a, rdata_b, busy_a, busy_b}, e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst      = 1'b1;
    we       = 1'b0;
    waddr    = '0;
    wdata    = '0;
    rsv      = 1'b0;
    rsv_addr = '0;
    raddr_a  = '0;
    raddr_b  = '0;
    @(posedge clk); #1;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_reserve();
    test_rsv_and_write();
    test_reset_dominates();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
